// File: rtl/text_raster_pkg.sv
// Shared types and constants for the character-mode raster generator.
package text_raster_pkg;

    // Frame sequencing states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int CHARS_PER_WORD = 16;
    localparam int GLYPH_W        = 8;
    localparam int GLYPH_H        = 16;
    localparam int DEFAULT_COLS   = 80;
    localparam int GROUPS         = DEFAULT_COLS / CHARS_PER_WORD;

    // Character code at position idx of a text word; char 0 sits in the top byte.
    function automatic logic [7:0] char_at(input logic [127:0] word, input logic [3:0] idx);
        int sel;
        sel = (CHARS_PER_WORD - 1 - int'(idx)) * 8;
        return word[sel +: 8];
    endfunction

endpackage

// File: rtl/text_raster_gen_glyph_serializer.sv
// Two-stage font-to-pixel pipeline: the font ROM answers one cycle after the
// issue, and the pixel is registered one cycle after that. The pixel index
// travels with the request so the right glyph bit is picked.
module glyph_serializer
    import text_raster_pkg::*;
#(
    parameter logic [23:0] FG_COLOR = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       issue_i,
    input  logic [$clog2(GLYPH_W)-1:0] px_i,
    input  logic [7:0]                 font_data_i,
    output logic [23:0]                pix_data_o,
    output logic                       pix_wr_en_o
);

    logic                       valid1_q;
    logic [$clog2(GLYPH_W)-1:0] px1_q;
    logic [23:0]                pix_data_q;
    logic                       pix_wr_en_q;

    // Stage 1: remember that a pixel was issued and which glyph bit it wants.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            px1_q    <= '0;
        end else begin
            valid1_q <= issue_i;
            px1_q    <= px_i;
        end
    end

    // Stage 2: font data is now valid; pick the bit (7 = leftmost) and colour it.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            pix_wr_en_q <= 1'b0;
            pix_data_q  <= BG_COLOR;
        end else begin
            pix_wr_en_q <= valid1_q;
            if (valid1_q) begin
                pix_data_q <= font_data_i[px1_q] ? FG_COLOR : BG_COLOR;
            end
        end
    end

    assign pix_data_o  = pix_data_q;
    assign pix_wr_en_o = pix_wr_en_q;

endmodule

// File: rtl/text_raster_gen.sv
// Character-mode raster generator: walks the text screen in SDRAM one pixel
// line at a time, re-reading each 16-character word for every glyph line, and
// streams 24-bit pixels into the pixel FIFO while honouring its prog_full flag.
module text_raster_gen
    import text_raster_pkg::*;
#(
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter int          ADDR_WIDTH  = 23,
    parameter int          DATA_WIDTH  = 128,
    parameter int          WORD_STRIDE = 8,
    parameter logic [23:0] FG_COLOR    = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR    = 24'h000000
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] text_base,
    output logic                  active,
    output logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_enable,
    input  logic                  mem_busy,
    input  logic                  mem_rd_ready,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [11:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic [23:0]           pix_data,
    output logic                  pix_wr_en,
    input  logic                  pix_almost_full,
    output logic [2:0]            dbg_state_o
);

    localparam int N_GROUPS = COLS / CHARS_PER_WORD;
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(N_GROUPS * WORD_STRIDE);

    // SDRAM read handshake: mem_rd_enable is held with a stable mem_rd_addr
    // until the controller raises mem_busy (request accepted); the word is then
    // taken on the single-cycle mem_rd_ready pulse, and a pulse in any other
    // state carries nothing for us and is dropped.
    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   row_addr_q;
    logic [ADDR_WIDTH-1:0]   mem_rd_addr_q;
    logic                    mem_rd_enable_q;
    logic [7:0]              row_q;
    logic [3:0]              line_q;
    logic [7:0]              group_q;
    logic [3:0]              char_idx_q;
    logic [2:0]              px_q;
    logic [DATA_WIDTH-1:0]   text_q;
    logic                    active_q;
    logic                    frame_done_q;
    logic                    drain_q;

    logic                    issue;
    logic                    last_px;
    logic                    last_char;
    logic                    last_group;
    logic                    last_line;
    logic                    last_row;
    logic [ADDR_WIDTH-1:0]   group_addr_d;
    logic [ADDR_WIDTH-1:0]   row_addr_d;

    // A pixel is issued in every EMIT cycle the FIFO is not near full.
    assign issue      = (state_q == EMIT) && !pix_almost_full;
    assign last_px    = (px_q == 3'd0);
    assign last_char  = (char_idx_q == 4'(CHARS_PER_WORD - 1));
    assign last_group = (group_q == 8'(N_GROUPS - 1));
    assign last_line  = (line_q == 4'(GLYPH_H - 1));
    assign last_row   = (row_q == 8'(ROWS - 1));

    // Next word addresses; arithmetic wraps silently at the address width.
    always_comb begin
        group_addr_d = row_addr_q + ADDR_WIDTH'((int'(group_q) + 1) * WORD_STRIDE);
        row_addr_d   = row_addr_q + ROW_STEP;
    end

    // Font lookup for the pixel being issued this cycle.
    assign font_addr = issue ? {char_at(text_q, char_idx_q), line_q} : 12'd0;

    // Frame FSM with counters, address generation and registered outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            row_addr_q      <= '0;
            mem_rd_addr_q   <= '0;
            mem_rd_enable_q <= 1'b0;
            row_q           <= '0;
            line_q          <= '0;
            group_q         <= '0;
            char_idx_q      <= '0;
            px_q            <= '0;
            text_q          <= '0;
            active_q        <= 1'b0;
            frame_done_q    <= 1'b0;
            drain_q         <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_addr_q      <= text_base;
                        mem_rd_addr_q   <= text_base;
                        mem_rd_enable_q <= 1'b1;
                        row_q           <= '0;
                        line_q          <= '0;
                        group_q         <= '0;
                        active_q        <= 1'b1;
                        state_q         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_busy) begin
                        mem_rd_enable_q <= 1'b0;
                        state_q         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rd_ready) begin
                        text_q     <= mem_rd_data;
                        char_idx_q <= '0;
                        px_q       <= 3'(GLYPH_W - 1);
                        state_q    <= EMIT;
                    end
                end
                EMIT: begin
                    if (issue) begin
                        if (!last_px) begin
                            px_q <= px_q - 3'd1;
                        end else if (!last_char) begin
                            char_idx_q <= char_idx_q + 4'd1;
                            px_q       <= 3'(GLYPH_W - 1);
                        end else if (!last_group) begin
                            group_q         <= group_q + 8'd1;
                            mem_rd_addr_q   <= group_addr_d;
                            mem_rd_enable_q <= 1'b1;
                            state_q         <= REQ;
                        end else begin
                            group_q <= '0;
                            if (!last_line) begin
                                line_q          <= line_q + 4'd1;
                                mem_rd_addr_q   <= row_addr_q;
                                mem_rd_enable_q <= 1'b1;
                                state_q         <= REQ;
                            end else if (!last_row) begin
                                line_q          <= '0;
                                row_q           <= row_q + 8'd1;
                                row_addr_q      <= row_addr_d;
                                mem_rd_addr_q   <= row_addr_d;
                                mem_rd_enable_q <= 1'b1;
                                state_q         <= REQ;
                            end else begin
                                line_q  <= '0;
                                drain_q <= 1'b0;
                                state_q <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles let the last issued pixel leave the pipeline.
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        frame_done_q <= 1'b1;
                        active_q     <= 1'b0;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    glyph_serializer #(
        .FG_COLOR (FG_COLOR),
        .BG_COLOR (BG_COLOR)
    ) u_glyph_serializer (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .issue_i     (issue),
        .px_i        (px_q),
        .font_data_i (font_data),
        .pix_data_o  (pix_data),
        .pix_wr_en_o (pix_wr_en)
    );

    assign active        = active_q;
    assign frame_done    = frame_done_q;
    assign mem_rd_addr   = mem_rd_addr_q;
    assign mem_rd_enable = mem_rd_enable_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_text_raster_gen.sv
// Bench for text_raster_gen on a reduced 32x2 text screen: SDRAM and font ROM
// models, a raster-order reference of reads and pixels, and directed frames
// covering plain, throttled, slow-memory, wrap and mid-frame reset cases.
`timescale 1ns/1ps
module tb_text_raster_gen;

    localparam int COLS   = 32;
    localparam int ROWS   = 2;
    localparam int AW     = 23;
    localparam int DW     = 128;
    localparam int STRIDE = 8;
    localparam int GROUPS = COLS / 16;
    localparam int PIX_PER_FRAME   = COLS * 8 * ROWS * 16;
    localparam int READS_PER_FRAME = ROWS * 16 * GROUPS;
    localparam int ROW1_PIX        = COLS * 8 * 16;
    localparam logic [23:0] FG = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h000000;

    // Clock and DUT signals
    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  text_base = '0;
    logic           active;
    logic           frame_done;
    logic [AW-1:0]  mem_rd_addr;
    logic           mem_rd_enable;
    logic           mem_busy = 1'b0;
    logic           mem_rd_ready = 1'b0;
    logic [DW-1:0]  mem_rd_data = '0;
    logic [11:0]    font_addr;
    logic [7:0]     font_data = '0;
    logic [23:0]    pix_data;
    logic           pix_wr_en;
    logic           pix_almost_full = 1'b0;
    logic [2:0]     dbg_state;

    always #5 sys_clk = ~sys_clk;

    text_raster_gen #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .start           (start),
        .text_base       (text_base),
        .active          (active),
        .frame_done      (frame_done),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_enable   (mem_rd_enable),
        .mem_busy        (mem_busy),
        .mem_rd_ready    (mem_rd_ready),
        .mem_rd_data     (mem_rd_data),
        .font_addr       (font_addr),
        .font_data       (font_data),
        .pix_data        (pix_data),
        .pix_wr_en       (pix_wr_en),
        .pix_almost_full (pix_almost_full),
        .dbg_state_o     (dbg_state)
    );

    // Scoreboard state
    int            tests = 0;
    int            fails = 0;
    logic [23:0]   exp_q[$];
    logic [AW-1:0] exp_rd_q[$];
    logic [23:0]   pix_log[$];
    logic [23:0]   ref_log[$];
    logic [AW-1:0] rd_log[$];
    int            n_done = 0;
    int            n_spur = 0;
    int            cyc = 0;
    int            last_wr_cyc = -10;

    // Stimulus knobs
    int mem_mode = 0;
    int busy_len = 1;
    int lat = 2;
    bit spur_en = 1'b0;
    bit throttle = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Text memory contents: either an address-derived pattern or 'A' then blanks.
    function automatic logic [127:0] word_fn(input logic [AW-1:0] a);
        logic [127:0] w;
        if (mem_mode == 1) return {8'h41, 120'h0};
        w = '0;
        for (int k = 0; k < 16; k++) begin
            w[127 - 8*k -: 8] = 8'(int'(a) * 3 + k * 37 + int'(a >> 8));
        end
        return w;
    endfunction

    // Font contents: code 0 is blank, 'A' line 0 is 0x18, the rest is hashed.
    function automatic logic [7:0] rom_fn(input logic [7:0] code, input logic [3:0] line);
        if (code == 8'h00) return 8'h00;
        if (code == 8'h41 && line == 4'd0) return 8'h18;
        return 8'(int'(code) * 11 ^ int'(line) * 53 ^ 8'h5A);
    endfunction

    // Raster-order reference: every pixel line re-reads each word of its char row.
    task automatic build_expected(input logic [AW-1:0] base);
        logic [127:0] w;
        logic [7:0]   code;
        logic [7:0]   g;
        logic [AW-1:0] a;
        int c;
        exp_q.delete();
        exp_rd_q.delete();
        for (int r = 0; r < ROWS; r++) begin
            for (int l = 0; l < 16; l++) begin
                for (int grp = 0; grp < GROUPS; grp++) begin
                    exp_rd_q.push_back(AW'(int'(base) + (r * GROUPS + grp) * STRIDE));
                end
                for (int x = 0; x < COLS * 8; x++) begin
                    c = x / 8;
                    a = AW'(int'(base) + (r * GROUPS + c / 16) * STRIDE);
                    w = word_fn(a);
                    code = w[127 - 8 * (c % 16) -: 8];
                    g = rom_fn(code, 4'(l));
                    exp_q.push_back(g[7 - (x % 8)] ? FG : BG);
                end
            end
        end
    endtask

    // Font ROM model: one cycle of latency.
    always @(posedge sys_clk) font_data <= rom_fn(font_addr[11:4], font_addr[3:0]);

    // SDRAM read port model: accept, stay busy, then deliver after a latency.
    int            m_st = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_addr = '0;
    always @(posedge sys_clk) begin
        mem_rd_ready <= 1'b0;
        mem_rd_data  <= {$urandom, $urandom, $urandom, $urandom};
        if (rst) begin
            m_st = 0;
            mem_busy <= 1'b0;
        end else begin
            case (m_st)
                0: begin
                    if (mem_rd_enable) begin
                        m_addr = mem_rd_addr;
                        rd_log.push_back(m_addr);
                        check("rd_expected", exp_rd_q.size() != 0, 1'b1);
                        if (exp_rd_q.size() != 0) check("rd_addr", m_addr, exp_rd_q.pop_front());
                        mem_busy <= 1'b1;
                        m_cnt = busy_len;
                        m_st = 1;
                    end else if (spur_en && dbg_state == 3'd3 && $urandom_range(0, 15) == 0) begin
                        mem_rd_ready <= 1'b1;
                        n_spur++;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_busy <= 1'b0;
                        m_cnt = lat;
                        m_st = 2;
                    end
                end
                default: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_rd_ready <= 1'b1;
                        mem_rd_data  <= word_fn(m_addr);
                        m_st = 0;
                    end
                end
            endcase
        end
    end

    // FIFO fullness driver and its per-cycle history.
    always @(negedge sys_clk) pix_almost_full = throttle ? 1'($urandom_range(0, 1)) : 1'b0;
    logic af_d1 = 1'b0;
    logic af_d2 = 1'b0;
    logic busy_seen = 1'b0;
    always @(posedge sys_clk) begin
        cyc++;
        af_d1     <= pix_almost_full;
        af_d2     <= af_d1;
        busy_seen <= mem_busy && mem_rd_enable && !rst;
    end

    // Output monitor: pixels, throttle response, request drop and frame end.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (busy_seen) check("rd_en_drop", mem_rd_enable, 1'b0);
            if (pix_wr_en) begin
                pix_log.push_back(pix_data);
                last_wr_cyc = cyc;
                check("pix_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("pix_data", pix_data, exp_q.pop_front());
                check("pix_after_af", af_d2, 1'b0);
            end
            if (frame_done) begin
                n_done++;
                check("done_after_last_pix", cyc - last_wr_cyc, 1);
                check("active_drop", active, 1'b0);
            end
        end
    end

    // Driver tasks
    task automatic start_frame(input logic [AW-1:0] base);
        build_expected(base);
        rd_log.delete();
        pix_log.delete();
        n_done = 0;
        @(negedge sys_clk);
        text_base = base;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n_done == 0 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        check({tag, "_completed"}, n_done != 0, 1'b1);
        repeat (3) @(negedge sys_clk);
        check({tag, "_done_once"}, n_done, 1);
        check({tag, "_pix_left"}, exp_q.size(), 0);
        check({tag, "_reads_left"}, exp_rd_q.size(), 0);
        check({tag, "_pix_count"}, pix_log.size(), PIX_PER_FRAME);
        check({tag, "_read_count"}, rd_log.size(), READS_PER_FRAME);
        check({tag, "_idle_inactive"}, active, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_active"}, active, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_rd_enable"}, mem_rd_enable, 1'b0);
        check({tag, "_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_font_addr"}, font_addr, 0);
        check({tag, "_wr_en"}, pix_wr_en, 1'b0);
        check({tag, "_pix_data"}, pix_data, BG);
        check({tag, "_state_idle"}, dbg_state, 3'd0);
    endtask

    logic [23:0] a_exp [16];

    initial begin
        int n;
        int diffs;
        a_exp = '{BG, BG, BG, FG, FG, BG, BG, BG, BG, BG, BG, BG, BG, BG, BG, BG};

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge sys_clk);

        // Plain frame with address-pattern text
        mem_mode = 0;
        start_frame(23'h000234);
        wait_done("basic", 30000);
        check("basic_rd0", (rd_log.size() > 0) ? rd_log[0] : 'x, 23'h000234);
        check("basic_rd1", (rd_log.size() > 1) ? rd_log[1] : 'x, 23'h00023C);
        check("basic_row1", (rd_log.size() > 16 * GROUPS) ? rd_log[16 * GROUPS] : 'x,
              23'h000234 + 23'(GROUPS * STRIDE));
        ref_log = pix_log;

        // Same frame with random FIFO backpressure
        throttle = 1'b1;
        start_frame(23'h000234);
        wait_done("throttle", 60000);
        throttle = 1'b0;
        check("throttle_len", pix_log.size(), ref_log.size());
        diffs = 0;
        for (int i = 0; i < pix_log.size() && i < ref_log.size(); i++) begin
            if (pix_log[i] !== ref_log[i]) diffs++;
        end
        check("throttle_stream", diffs, 0);

        // Slow memory, spurious ready, address wrap and ignored start
        busy_len = 20;
        lat = 30;
        spur_en = 1'b1;
        start_frame(23'h7FFFF8);
        n = 0;
        while (pix_log.size() < ROW1_PIX + 50 && n < 30000) begin
            @(negedge sys_clk);
            n++;
        end
        check("slow_reach_row1", pix_log.size() >= ROW1_PIX + 50, 1'b1);
        text_base = 23'h000100;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done("slow_wrap", 40000);
        check("wrap_rd0", (rd_log.size() > 0) ? rd_log[0] : 'x, 23'h7FFFF8);
        check("wrap_rd1", (rd_log.size() > 1) ? rd_log[1] : 'x, 23'h000000);
        check("spurious_injected", n_spur != 0, 1'b1);
        busy_len = 1;
        lat = 2;
        spur_en = 1'b0;

        // Reset in the middle of char row 1, then restart from a new base
        start_frame(23'h000234);
        n = 0;
        while ((pix_log.size() < ROW1_PIX + 100 || dbg_state != 3'd3) && n < 20000) begin
            @(negedge sys_clk);
            n++;
        end
        check("reset_reach_emit", dbg_state, 3'd3);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        exp_rd_q.delete();
        repeat (2) begin
            @(negedge sys_clk);
            check("rst_no_write", pix_wr_en, 1'b0);
            check("rst_no_read", mem_rd_enable, 1'b0);
        end
        rst = 1'b0;
        @(negedge sys_clk);
        mem_mode = 1;
        start_frame(23'h000040);
        wait_done("after_reset", 30000);
        check("restart_rd0", (rd_log.size() > 0) ? rd_log[0] : 'x, 23'h000040);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("glyph_A_px%0d", i), (pix_log.size() > i) ? pix_log[i] : 'x, a_exp[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
